// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined RSA processor: owns the data-memory port for host
// access while the CPU is idle, then sequences reset -> run -> halt/timeout/abort.
module cpu_run_controller #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_go,
  input  logic        i_abort,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  input  logic        i_host_write,
  input  logic [31:0] i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic [31:0] o_host_rdata,
  output logic        o_host_rvalid,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_status,
  output logic [31:0] o_cycle_count,
  output logic        o_cpu_reset,
  output logic        o_cpu_start,
  input  logic        i_cpu_halt,
  input  logic        i_cpu_memwrite,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_HRD0, S_HRD1, S_RST, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORT   = 2'b11
  } status_t;

  localparam logic [31:0] LP_LAST_RUN  = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] LP_RST_LOAD  = 32'(RESET_CYCLES - 1);

  state_t      r_state;
  status_t     r_status;
  logic [31:0] r_cycle_count;
  logic [31:0] r_rst_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_host_rdata;
  logic        r_host_rvalid;
  logic        r_busy;
  logic        r_done;
  logic        r_cpu_reset;
  logic        r_cpu_start;

  logic w_idle;
  logic w_run;
  logic w_hrd;
  logic w_host_acc;

  assign w_idle       = (r_state == S_IDLE);
  assign w_run        = (r_state == S_RUN);
  assign w_hrd        = (r_state == S_HRD0) || (r_state == S_HRD1);
  assign o_host_ready = w_idle & ~i_go;
  assign w_host_acc   = i_host_valid & o_host_ready;

  // CPU owns the memory port only in RUN; otherwise the host side drives it, and
  // a pending read keeps its latched address so registered memories see it stable.
  assign o_mem_we    = w_run ? i_cpu_memwrite : (w_host_acc & i_host_write);
  assign o_mem_addr  = w_run ? i_cpu_addr : (w_hrd ? r_addr : i_host_addr);
  assign o_mem_wdata = w_run ? i_cpu_wdata : i_host_wdata;

  assign o_host_rdata  = r_host_rdata;
  assign o_host_rvalid = r_host_rvalid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_status      = r_status;
  assign o_cycle_count = r_cycle_count;
  assign o_cpu_reset   = r_cpu_reset;
  assign o_cpu_start   = r_cpu_start;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_status      <= ST_NONE;
      r_cycle_count <= '0;
      r_rst_cnt     <= '0;
      r_addr        <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_cpu_start   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins.
      r_host_rvalid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_state       <= S_RST;
            r_status      <= ST_NONE;
            r_cycle_count <= '0;
            r_rst_cnt     <= LP_RST_LOAD;
            r_busy        <= 1'b1;
          end else if (w_host_acc && !i_host_write) begin
            r_addr  <= i_host_addr;
            r_state <= S_HRD0;
          end
        end
        S_HRD0: r_state <= S_HRD1;
        S_HRD1: begin
          r_host_rdata  <= i_mem_rdata;
          r_host_rvalid <= 1'b1;
          r_state       <= S_IDLE;
        end
        S_RST: begin
          if (r_rst_cnt == '0) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_cpu_start <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - 32'd1;
          end
        end
        S_RUN: begin
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
          if (i_abort || i_cpu_halt || (r_cycle_count == LP_LAST_RUN)) begin
            r_state     <= S_FIN;
            r_status    <= i_abort ? ST_ABORT : (i_cpu_halt ? ST_HALT : ST_TIMEOUT);
            r_cpu_reset <= 1'b1;
            r_cpu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: a cycle-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cpu_run_controller;

  localparam int unsigned RESET_CYCLES = 4;
  localparam int unsigned MAX_CYCLES   = 16;

  logic        i_clk = 1'b0;
  logic        i_reset, i_go, i_abort;
  logic        i_host_valid, i_host_write;
  logic [31:0] i_host_addr, i_host_wdata;
  logic        o_host_ready, o_host_rvalid;
  logic [31:0] o_host_rdata;
  logic        o_busy, o_done;
  logic [1:0]  o_status;
  logic [31:0] o_cycle_count;
  logic        o_cpu_reset, o_cpu_start;
  logic        i_cpu_halt, i_cpu_memwrite;
  logic [31:0] i_cpu_addr, i_cpu_wdata;
  logic        o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_controller #(.RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_go(i_go), .i_abort(i_abort),
    .i_host_valid(i_host_valid), .o_host_ready(o_host_ready), .i_host_write(i_host_write),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .o_host_rdata(o_host_rdata),
    .o_host_rvalid(o_host_rvalid), .o_busy(o_busy), .o_done(o_done), .o_status(o_status),
    .o_cycle_count(o_cycle_count), .o_cpu_reset(o_cpu_reset), .o_cpu_start(o_cpu_start),
    .i_cpu_halt(i_cpu_halt), .i_cpu_memwrite(i_cpu_memwrite), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment data memory with combinational read.
  logic [31:0] env_mem [0:255];
  assign i_mem_rdata = env_mem[o_mem_addr[9:2]];
  always @(posedge i_clk) if (o_mem_we === 1'b1) env_mem[o_mem_addr[9:2]] <= o_mem_wdata;

  // Reference model: phase counters describe where the controller is in its run.
  logic [31:0] m_mem [0:255];
  bit          m_valid = 0;
  int          m_rst_left, m_run_n, m_rd_wait;
  bit          m_fin, m_rvalid;
  logic [31:0] m_rdata, m_rd_addr, m_count;
  logic [1:0]  m_status;
  bit          e_run, e_idle, e_ready, e_acc;

  always @(negedge i_clk) begin
    e_run   = (m_run_n > 0);
    e_idle  = (m_rst_left == 0) && !e_run && !m_fin && (m_rd_wait == 0);
    e_ready = e_idle && !i_go;
    e_acc   = e_ready && i_host_valid;
    if (m_valid) begin
      check("host_ready",  o_host_ready, e_ready);
      check("mem_we",      o_mem_we, e_run ? i_cpu_memwrite : (e_acc & i_host_write));
      check("mem_addr",    o_mem_addr, e_run ? i_cpu_addr : (m_rd_wait > 0 ? m_rd_addr : i_host_addr));
      check("mem_wdata",   o_mem_wdata, e_run ? i_cpu_wdata : i_host_wdata);
      check("busy",        o_busy, (m_rst_left > 0) || e_run);
      check("done",        o_done, m_fin);
      check("cpu_reset",   o_cpu_reset, !e_run);
      check("cpu_start",   o_cpu_start, e_run);
      check("status",      o_status, m_status);
      check("cycle_count", o_cycle_count, e_run ? 32'(m_run_n - 1) : m_count);
      check("host_rvalid", o_host_rvalid, m_rvalid);
      check("host_rdata",  o_host_rdata, m_rdata);
    end
    if (i_reset) begin
      m_valid = 1; m_rst_left = 0; m_run_n = 0; m_rd_wait = 0; m_fin = 0;
      m_rvalid = 0; m_rdata = 0; m_rd_addr = 0; m_count = 0; m_status = 0;
    end else begin
      m_rvalid = (m_rd_wait == 1);
      if (m_rd_wait == 1) m_rdata = m_mem[m_rd_addr[9:2]];
      if (m_rd_wait > 0) m_rd_wait--;
      m_fin = 0;
      if (e_run) begin
        if (i_cpu_memwrite) m_mem[i_cpu_addr[9:2]] = i_cpu_wdata;
        m_count = 32'(m_run_n);
        if (i_abort || i_cpu_halt || m_run_n == int'(MAX_CYCLES)) begin
          m_status = i_abort ? 2'b11 : (i_cpu_halt ? 2'b01 : 2'b10);
          m_run_n  = 0;
          m_fin    = 1;
        end else begin
          m_run_n++;
        end
      end else if (m_rst_left > 0) begin
        m_rst_left--;
        if (m_rst_left == 0) m_run_n = 1;
      end else if (e_idle) begin
        if (i_go) begin
          m_rst_left = int'(RESET_CYCLES); m_status = 0; m_count = 0;
        end else if (e_acc) begin
          if (i_host_write) m_mem[i_host_addr[9:2]] = i_host_wdata;
          else begin m_rd_wait = 2; m_rd_addr = i_host_addr; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic host_read(input logic [31:0] addr, input logic [31:0] exp);
    bit got = 0;
    int lat = 0;
    tick(); i_host_valid = 1; i_host_write = 0; i_host_addr = addr;
    @(negedge i_clk);
    tick(); i_host_valid = 0; i_host_addr = 32'h0000_0080;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge i_clk);
      if (o_host_rvalid === 1'b1) begin got = 1; lat = k; end
      else tick();
    end
    check("read_rvalid_seen", 32'(got), 32'd1);
    check("read_latency", 32'(lat), 32'd2);
    check("read_data", o_host_rdata, exp);
  endtask

  task automatic start_run();
    tick(); i_go = 1;
    @(negedge i_clk);
    for (int k = 0; k < int'(RESET_CYCLES); k++) begin
      tick(); i_go = 0;
      @(negedge i_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int runs;
    for (int k = 0; k < 256; k++) begin env_mem[k] = '0; m_mem[k] = '0; end
    i_reset = 1; i_go = 0; i_abort = 0; i_host_valid = 0; i_host_write = 0;
    i_host_addr = 0; i_host_wdata = 0; i_cpu_halt = 0; i_cpu_memwrite = 0;
    i_cpu_addr = 0; i_cpu_wdata = 0;
    tick(); tick(); i_reset = 0;
    @(negedge i_clk);
    check("rst_cpu_reset", o_cpu_reset, 1'b1);
    check("rst_cpu_start", o_cpu_start, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_status", o_status, 2'b00);
    check("rst_count", o_cycle_count, 32'd0);
    check("rst_rdata", o_host_rdata, 32'd0);

    // Host write, then read back through HRD0/HRD1; go during HRD0 must be ignored.
    tick(); i_host_valid = 1; i_host_write = 1; i_host_addr = 32'h40; i_host_wdata = 32'hDEADBEEF;
    @(negedge i_clk);
    check("wr_mem_we", o_mem_we, 1'b1);
    tick(); i_host_valid = 0; i_host_write = 0;
    @(negedge i_clk);
    check("wr_mem_we_off", o_mem_we, 1'b0);
    tick(); i_host_valid = 1; i_host_addr = 32'h40;
    @(negedge i_clk);
    tick(); i_host_valid = 0; i_host_addr = 32'h80; i_go = 1;
    @(negedge i_clk);
    check("hrd0_ready", o_host_ready, 1'b0);
    tick(); i_go = 0;
    @(negedge i_clk);
    check("hrd1_addr", o_mem_addr, 32'h40);
    check("hrd1_rvalid", o_host_rvalid, 1'b0);
    tick();
    @(negedge i_clk);
    check("rd_rvalid", o_host_rvalid, 1'b1);
    check("rd_data", o_host_rdata, 32'hDEADBEEF);
    check("rd_go_ignored", o_busy, 1'b0);

    // Halt on the 10th RUN cycle; halt raised during RST must be ignored.
    tick(); i_go = 1;
    @(negedge i_clk);
    for (int k = 0; k < int'(RESET_CYCLES); k++) begin
      tick(); i_go = 0; i_cpu_halt = 1;
      @(negedge i_clk);
      check("halt_rst_phase", o_cpu_reset, 1'b1);
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      i_cpu_halt = (i == 10); i_cpu_addr = 32'(32'h100 + 4 * i);
      i_cpu_memwrite = i[0]; i_cpu_wdata = 32'(i * 32'h11);
      i_host_valid = 1; i_host_write = 1;
      @(negedge i_clk);
      check("halt_run_start", o_cpu_start, 1'b1);
      check("halt_run_ready", o_host_ready, 1'b0);
    end
    tick(); i_cpu_halt = 0; i_cpu_memwrite = 0; i_host_valid = 0; i_host_write = 0;
    @(negedge i_clk);
    check("halt_done", o_done, 1'b1);
    check("halt_status", o_status, 2'b01);
    check("halt_count", o_cycle_count, 32'd10);
    tick();
    @(negedge i_clk);
    check("halt_done_off", o_done, 1'b0);
    host_read(32'h104, 32'h11);

    // Timeout after MAX_CYCLES RUN cycles.
    start_run();
    got = 0; runs = 0;
    tick();
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge i_clk);
      if (o_cpu_start === 1'b1) runs++;
      if (o_done === 1'b1) got = 1;
      else tick();
    end
    check("to_done_seen", 32'(got), 32'd1);
    check("to_run_cycles", 32'(runs), 32'd16);
    check("to_status", o_status, 2'b10);
    check("to_count", o_cycle_count, 32'd16);

    // Abort and halt together on the 3rd RUN cycle: abort wins.
    start_run();
    tick(); @(negedge i_clk);
    tick(); @(negedge i_clk);
    tick(); i_abort = 1; i_cpu_halt = 1;
    @(negedge i_clk);
    tick(); i_abort = 0; i_cpu_halt = 0;
    @(negedge i_clk);
    check("ab_status", o_status, 2'b11);
    check("ab_count", o_cycle_count, 32'd3);

    // go together with a host write: write refused, RST entered.
    tick(); i_go = 1; i_host_valid = 1; i_host_write = 1; i_host_addr = 32'h44; i_host_wdata = 32'h12345678;
    @(negedge i_clk);
    check("gow_mem_we", o_mem_we, 1'b0);
    check("gow_ready", o_host_ready, 1'b0);
    tick(); i_go = 0; i_host_valid = 0; i_host_write = 0;
    @(negedge i_clk);
    check("gow_busy", o_busy, 1'b1);
    check("gow_status_clr", o_status, 2'b00);
    for (int k = 1; k < int'(RESET_CYCLES); k++) begin tick(); @(negedge i_clk); end
    tick(); i_abort = 1;
    @(negedge i_clk);
    tick(); i_abort = 0;
    @(negedge i_clk);
    check("gow_abort_count", o_cycle_count, 32'd1);
    host_read(32'h44, 32'h0);

    // Synchronous reset on the 5th RUN cycle.
    start_run();
    for (int i = 1; i <= 5; i++) begin
      tick(); if (i == 5) i_reset = 1;
      @(negedge i_clk);
      check("mid_run_start", o_cpu_start, 1'b1);
    end
    tick(); i_reset = 0;
    @(negedge i_clk);
    check("mid_cpu_reset", o_cpu_reset, 1'b1);
    check("mid_done", o_done, 1'b0);
    check("mid_status", o_status, 2'b00);
    check("mid_count", o_cycle_count, 32'd0);

    // Reset during a host read drops the pending return.
    tick(); i_host_valid = 1; i_host_write = 0; i_host_addr = 32'h40;
    @(negedge i_clk);
    tick(); i_host_valid = 0; i_reset = 1;
    @(negedge i_clk);
    tick(); i_reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      check("drop_rvalid", o_host_rvalid, 1'b0);
      tick();
    end
    host_read(32'h40, 32'hDEADBEEF);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run controller for the pipelined RSA processor system. It owns the data memory port while the CPU is idle, so a host can load operands and read results. It sequences a run by holding the CPU in reset, releasing it with `start`, and detecting halt via the processor's `FlagZero`. Every run is bounded by a cycle-count timeout. It sits between the host, `pipelined_processor` and `data_mem`, and muxes the data memory port between host and CPU.

## Interface
- `RESET_CYCLES`, default 4: cycles `cpu_reset` is held high after `go` before the run starts (≥1).
- `MAX_CYCLES`, default 1000000: run cycles before timeout (≥2, fits 32 bits).
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `go` in 1: run request pulse; honoured only in IDLE.
- `abort` in 1: terminates a run; honoured only in RUN.
- `host_valid` in 1: host access request.
- `host_ready` out 1: access accepted when `host_valid & host_ready`.
- `host_write` in 1: 1 = write, 0 = read.
- `host_addr` in 32: byte address.
- `host_wdata` in 32: write data.
- `host_rdata` out 32: read data, valid with `host_rvalid`.
- `host_rvalid` out 1: one-cycle read-return pulse.
- `busy` out 1: high in RST and RUN.
- `done` out 1: one-cycle pulse at run end.
- `status` out 2: 00 none, 01 halted, 10 timeout, 11 aborted; held until the next `go`.
- `cycle_count` out 32: RUN cycles of the last or current run.
- `cpu_reset` out 1: to processor `reset`.
- `cpu_start` out 1: to processor `start`.
- `cpu_halt` in 1: processor `FlagZero`.
- `cpu_memwrite` in 1: processor `MemWrite`.
- `cpu_addr` in 32: processor `ALUResult`.
- `cpu_wdata` in 32: processor `WriteData`.
- `mem_we` out 1: to `data_mem` `WriteEnable`.
- `mem_addr` out 32: to `data_mem` `DataAddress`.
- `mem_wdata` out 32: to `data_mem` `WriteData`.
- `mem_rdata` in 32: from `data_mem` `ReadData`; also routed directly to the CPU.

## Operation
- States: IDLE, HRD0, HRD1, RST, RUN, FIN.
- Memory mux:
  - In RUN, `mem_we/addr/wdata` = `cpu_memwrite/cpu_addr/cpu_wdata`, combinational passthrough.
  - In all other states the host side drives the port. `mem_we` is 1 only on an accepted host write.
- `cpu_reset` = 1 in every state except RUN. `cpu_start` = 1 only in RUN.
- IDLE:
  - `host_ready` = `~go`.
  - Accepted write: `mem_we`=1 that cycle; stay in IDLE.
  - Accepted read: latch `host_addr` into the address register; go to HRD0.
  - `go`=1: go to RST. `go` wins over a same-cycle `host_valid`, since `host_ready` is 0.
- HRD0, HRD1:
  - `host_ready`=0; `mem_addr` held at the latched address.
  - End of HRD1: capture `mem_rdata` into `host_rdata`; pulse `host_rvalid` in the next cycle (IDLE).
  - This covers both combinational and 1-cycle registered `data_mem` reads.
  - `go` in HRD0/HRD1 is ignored.
- RST:
  - On entry: `status`:=00, `cycle_count`:=0, reset counter loaded.
  - Stay `RESET_CYCLES` cycles, then go to RUN.
- RUN: `cycle_count` increments each cycle, saturating at 2^32−1. Exit priority, highest first:
  1. `abort` → `status` 11.
  2. `cpu_halt` → `status` 01.
  3. `cycle_count` == `MAX_CYCLES`−1 → `status` 10.
- Any RUN exit goes to FIN.
  - `done`=1 for that one FIN cycle; `cpu_reset` reasserts.
  - FIN then returns to IDLE.
- `host_rdata` holds its last value. `host_rvalid` is low except for its single pulse.
- Other inputs outside the listed states are don't-care.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `cpu_start`=0, `busy`=0, `done`=0, `status`=00, `cycle_count`=0, `host_rvalid`=0, `host_rdata`=0, `mem_we`=0.
- Reset mid-RUN: next cycle is IDLE with `cpu_reset`=1. No `done` pulse; any in-flight read is dropped.
- `go` sampled at edge t puts RST in cycle t+1. RUN spans t+1+`RESET_CYCLES` onward.
- Host write latency: 0 cycles (same-cycle `mem_we`).
- Host read latency: accept cycle t → `host_rvalid` in cycle t+3. Back-to-back reads therefore take 3 cycles each.
- `cycle_count` at `done` equals the number of RUN cycles, including the exit cycle.
- Timeout fires on exactly the `MAX_CYCLES`-th RUN cycle.
- `cpu_halt` high while `cpu_reset` is high is ignored.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x40, then read 0x40 → `mem_we` pulse at write; `host_rvalid` 3 cycles after read accept with `host_rdata`=0xDEADBEEF.
- `go` pulse, `cpu_halt` raised on 10th RUN cycle → `cpu_reset` high 4 cycles, `cpu_start` high 10 cycles, `done` pulse, `status`=01, `cycle_count`=10.
- `MAX_CYCLES`=16, `cpu_halt` never set → `done` after 16 RUN cycles, `status`=10, `cycle_count`=16.
- `abort` and `cpu_halt` high in the same RUN cycle → `status`=11; during RUN, `mem_addr`/`mem_we` track `cpu_addr`/`cpu_memwrite` and host requests see `host_ready`=0.
- `go` and `host_valid` write together in IDLE → write not accepted (`mem_we`=0), RST entered.
- `reset` asserted on 5th RUN cycle → next cycle IDLE, `cpu_reset`=1, `done`=0, `status`=00, `cycle_count`=0.
